// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcodes and handshake structs.
package alu_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int NUM_WORD_WIDTH = 4;

    typedef logic [DATA_WIDTH-1:0] uint_t;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        MUL  = 3'd2,
        DIV  = 3'd3,
        MEAN = 3'd4
    } ALU_OP_E;

    typedef struct packed {
        logic  vld;
        uint_t data;
    } uint_vld_t;

    typedef struct packed {
        logic                      vld;
        ALU_OP_E                   opcode;
        logic [NUM_WORD_WIDTH-1:0] num_words;
    } alu_cmd_t;
endpackage

// File: rtl/alu_req_issuer.sv
// alu_req_issuer: sequences one host request into ALU command/operand beats
// and returns a single response, with illegal-request and timeout handling.
module alu_req_issuer
    import alu_pkg::*;
#(
    parameter int TIMEOUT   = 64,
    parameter int MAX_WORDS = 2**NUM_WORD_WIDTH-1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_vld,
    output logic                      req_rdy,
    input  ALU_OP_E                   req_opcode,
    input  logic [NUM_WORD_WIDTH-1:0] req_num_words,
    input  uint_t                     req_a,
    input  uint_t                     req_b,
    input  logic                      wd_vld,
    output logic                      wd_rdy,
    input  uint_t                     wd_data,
    output alu_cmd_t                  alu_cmd,
    output uint_vld_t                 operand_a,
    output uint_vld_t                 operand_b,
    input  uint_vld_t                 result,
    output logic                      rsp_vld,
    input  logic                      rsp_rdy,
    output uint_t                     rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);
    localparam int TW = $clog2(TIMEOUT+1);

    typedef enum logic [2:0] {IDLE, CMD, OPS, MEAN_OPS, WAIT, RESP} state_t;

    state_t                    state;
    ALU_OP_E                   op;
    logic [NUM_WORD_WIDTH-1:0] nwords;
    logic [NUM_WORD_WIDTH-1:0] wcnt;
    logic [TW-1:0]             tcnt;
    uint_t                     a_q;
    uint_t                     b_q;
    uint_vld_t                 op_a_q;
    logic                      illegal;

    assign illegal = (req_opcode > MEAN) ||
                     (req_opcode == MEAN &&
                      (req_num_words == '0 || int'(req_num_words) > MAX_WORDS));

    assign req_rdy = state == IDLE;
    assign busy    = state != IDLE;
    assign wd_rdy  = state == MEAN_OPS;

    // MEAN words bypass the register so each accepted word reaches the ALU in its own cycle
    assign operand_a = (state == MEAN_OPS) ? '{vld: wd_vld, data: wd_vld ? wd_data : '0} : op_a_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            op        <= ADD;
            nwords    <= '0;
            wcnt      <= '0;
            tcnt      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_a_q    <= '0;
            operand_b <= '0;
            alu_cmd   <= '0;
            rsp_vld   <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_vld) begin
                    op     <= req_opcode;
                    nwords <= req_num_words;
                    a_q    <= req_a;
                    b_q    <= req_b;
                    if (illegal) begin
                        state    <= RESP;
                        rsp_vld  <= 1'b1;
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end else begin
                        state   <= CMD;
                        alu_cmd <= '{vld: 1'b1, opcode: req_opcode,
                                     num_words: (req_opcode == MEAN) ? req_num_words : '0};
                    end
                end
                CMD: begin
                    alu_cmd <= '0;
                    if (op == MEAN) begin
                        state <= MEAN_OPS;
                        wcnt  <= '0;
                    end else begin
                        state     <= OPS;
                        op_a_q    <= '{vld: 1'b1, data: a_q};
                        operand_b <= '{vld: 1'b1, data: b_q};
                    end
                end
                OPS: begin
                    op_a_q    <= '0;
                    operand_b <= '0;
                    tcnt      <= '0;
                    state     <= WAIT;
                end
                MEAN_OPS: if (wd_vld) begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == nwords - 1'b1) begin
                        state <= WAIT;
                        tcnt  <= '0;
                    end
                end
                WAIT: begin
                    // a result arriving on the final count still wins over the timeout
                    if (result.vld) begin
                        state    <= RESP;
                        rsp_vld  <= 1'b1;
                        rsp_err  <= 1'b0;
                        rsp_data <= result.data;
                    end else if (tcnt == TW'(TIMEOUT-1)) begin
                        state    <= RESP;
                        rsp_vld  <= 1'b1;
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: if (rsp_rdy) begin
                    state    <= IDLE;
                    rsp_vld  <= 1'b0;
                    rsp_err  <= 1'b0;
                    rsp_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_issuer.sv
// tb_alu_req_issuer: directed vectors for alu_req_issuer with hand-computed
// expectations for ADD, MEAN, DIV timeout, illegal requests, backpressure and reset.
module tb_alu_req_issuer;
    import alu_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      req_vld = 1'b0;
    logic                      req_rdy;
    ALU_OP_E                   req_opcode = ADD;
    logic [NUM_WORD_WIDTH-1:0] req_num_words = '0;
    uint_t                     req_a = '0;
    uint_t                     req_b = '0;
    logic                      wd_vld = 1'b0;
    logic                      wd_rdy;
    uint_t                     wd_data = '0;
    alu_cmd_t                  alu_cmd;
    uint_vld_t                 operand_a;
    uint_vld_t                 operand_b;
    uint_vld_t                 result = '0;
    logic                      rsp_vld;
    logic                      rsp_rdy = 1'b1;
    uint_t                     rsp_data;
    logic                      rsp_err;
    logic                      busy;

    int n_checks = 0;
    int n_errors = 0;
    int alu_vld_cnt = 0;

    always #5 clk = ~clk;

    alu_req_issuer dut (
        .clk(clk), .reset_n(reset_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_opcode(req_opcode),
        .req_num_words(req_num_words), .req_a(req_a), .req_b(req_b),
        .wd_vld(wd_vld), .wd_rdy(wd_rdy), .wd_data(wd_data),
        .alu_cmd(alu_cmd), .operand_a(operand_a), .operand_b(operand_b),
        .result(result), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always @(negedge clk)
        if (alu_cmd.vld || operand_a.vld || operand_b.vld) alu_vld_cnt <= alu_vld_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input ALU_OP_E op, input logic [NUM_WORD_WIDTH-1:0] nw,
                         input uint_t a, input uint_t b);
        req_vld       = 1'b1;
        req_opcode    = op;
        req_num_words = nw;
        req_a         = a;
        req_b         = b;
        tick();
        req_vld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic    vlds[6];
        uint_t   words[6];
        int      n;
        int      pulses;
        int      base;
        vlds  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        words = '{32'd2, 32'd4, 32'd99, 32'd99, 32'd6, 32'd8};

        repeat (3) tick();
        reset_n = 1'b1;
        chk("rst_req_rdy", 64'(req_rdy), 1);
        chk("rst_wd_rdy", 64'(wd_rdy), 0);
        chk("rst_alu_cmd", 64'(alu_cmd), 0);
        chk("rst_op_a", 64'(operand_a), 0);
        chk("rst_op_b", 64'(operand_b), 0);
        chk("rst_rsp", 64'({rsp_vld, rsp_err, rsp_data}), 0);
        chk("rst_busy", 64'(busy), 0);

        // ADD 5+7
        issue(ADD, 4'd3, 32'd5, 32'd7);
        chk("add_cmd", 64'(alu_cmd), 64'({1'b1, ADD, 4'd0}));
        chk("add_busy", 64'(busy), 1);
        chk("add_req_rdy", 64'(req_rdy), 0);
        chk("add_op_a_idle", 64'(operand_a.vld), 0);
        tick();
        chk("add_op_a", 64'(operand_a), 64'({1'b1, 32'd5}));
        chk("add_op_b", 64'(operand_b), 64'({1'b1, 32'd7}));
        chk("add_cmd_off", 64'(alu_cmd), 0);
        tick();
        chk("add_op_a_off", 64'(operand_a), 0);
        repeat (2) tick();
        result = '{vld: 1'b1, data: 32'd12};
        tick();
        result = '0;
        chk("add_rsp_vld", 64'(rsp_vld), 1);
        chk("add_rsp_data", 64'(rsp_data), 12);
        chk("add_rsp_err", 64'(rsp_err), 0);
        tick();
        chk("add_idle", 64'({req_rdy, busy, rsp_vld}), 64'(3'b100));

        // MEAN of 2,4,6,8 with a gap after the second word
        issue(MEAN, 4'd4, 32'd0, 32'd0);
        chk("mean_cmd", 64'(alu_cmd), 64'({1'b1, MEAN, 4'd4}));
        tick();
        chk("mean_wd_rdy", 64'(wd_rdy), 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            wd_vld  = vlds[i];
            wd_data = words[i];
            #1;
            chk($sformatf("mean_w%0d", i), 64'(operand_a),
                vlds[i] ? 64'({1'b1, words[i]}) : 64'd0);
            chk($sformatf("mean_b%0d", i), 64'(operand_b.vld), 0);
            if (operand_a.vld) pulses++;
            tick();
        end
        wd_vld = 1'b0;
        chk("mean_pulses", 64'(pulses), 4);
        chk("mean_wd_rdy_off", 64'(wd_rdy), 0);
        result = '{vld: 1'b1, data: 32'd5};
        tick();
        result = '0;
        chk("mean_rsp", 64'({rsp_vld, rsp_err, rsp_data}), 64'({2'b10, 32'd5}));
        tick();

        // DIV with a silent ALU times out 64 cycles after WAIT entry
        issue(DIV, 4'd0, 32'd9, 32'd2);
        tick();
        chk("div_op_a", 64'(operand_a), 64'({1'b1, 32'd9}));
        chk("div_op_b", 64'(operand_b), 64'({1'b1, 32'd2}));
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_vld && n < 200);
        chk("div_timeout_lat", 64'(n), 65);
        chk("div_rsp", 64'({rsp_vld, rsp_err, rsp_data}), 64'({2'b11, 32'd0}));
        tick();

        // result on the final timeout cycle wins
        issue(DIV, 4'd0, 32'd84, 32'd2);
        tick();
        repeat (64) tick();
        chk("race_no_rsp_yet", 64'(rsp_vld), 0);
        result = '{vld: 1'b1, data: 32'd42};
        tick();
        result = '0;
        chk("race_rsp", 64'({rsp_vld, rsp_err, rsp_data}), 64'({2'b10, 32'd42}));
        tick();

        // illegal opcode 7
        base = alu_vld_cnt;
        issue(ALU_OP_E'(3'd7), 4'd0, 32'd1, 32'd1);
        n = 1;
        while (!rsp_vld && n < 3) begin
            tick();
            n++;
        end
        chk("ill7_lat_ok", 64'(n <= 2), 1);
        chk("ill7_rsp", 64'({rsp_vld, rsp_err, rsp_data}), 64'({2'b11, 32'd0}));
        tick();
        chk("ill7_no_alu_vld", 64'(alu_vld_cnt - base), 0);

        // MEAN with zero words is illegal
        base = alu_vld_cnt;
        issue(MEAN, 4'd0, 32'd0, 32'd0);
        n = 1;
        while (!rsp_vld && n < 3) begin
            tick();
            n++;
        end
        chk("mean0_lat_ok", 64'(n <= 2), 1);
        chk("mean0_rsp", 64'({rsp_vld, rsp_err, rsp_data}), 64'({2'b11, 32'd0}));
        tick();
        chk("mean0_no_alu_vld", 64'(alu_vld_cnt - base), 0);
        chk("mean0_idle", 64'(req_rdy), 1);

        // SUB 10-3 under response backpressure
        rsp_rdy = 1'b0;
        issue(SUB, 4'd0, 32'd10, 32'd3);
        repeat (2) tick();
        result = '{vld: 1'b1, data: 32'd7};
        tick();
        result = '0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sub_hold%0d", i), 64'({rsp_vld, rsp_err, req_rdy, rsp_data}),
                64'({3'b100, 32'd7}));
            tick();
        end
        rsp_rdy = 1'b1;
        chk("sub_hold_last", 64'({rsp_vld, rsp_data}), 64'({1'b1, 32'd7}));
        tick();
        chk("sub_done", 64'({req_rdy, rsp_vld}), 64'(2'b10));

        // reset during WAIT, then a stale result
        issue(ADD, 4'd0, 32'd1, 32'd1);
        repeat (3) tick();
        chk("rst_wait_busy", 64'(busy), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        result = '{vld: 1'b1, data: 32'd99};
        tick();
        result = '0;
        chk("late_res_rsp", 64'(rsp_vld), 0);
        chk("late_res_idle", 64'({busy, req_rdy}), 64'(2'b01));
        repeat (3) tick();
        chk("late_res_quiet", 64'({rsp_vld, busy, alu_cmd.vld}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
